hdlc_framer: RTL and testbench
==============================

# hdlc_framer

Upstream companion of the NABU transmitter (SDLC zero-insertion / scrambler stage). It buffers payload bytes from the host and wraps each frame in HDLC framing: an opening flag, the payload, a 16-bit FCS and a closing flag. Between frames it sends idle flags, and it sends an abort if the frame underruns. Its output is 9-bit words `{raw, byte}` written into the transmitter's holding register under the THRE handshake, so the host no longer has to pace bytes in real time.

## Interface
- `FIFO_DEPTH`, 16: payload FIFO entries. Power of two, 4..64.
- `MIN_FLAGS`, 1: minimum flags sent between the end of a closing flag or abort and the next frame's first payload byte. 1..15.
- `BIT_CLK` in 1: bit clock, the same net as the transmitter's bit clock. Only clock.
- `nRESET` in 1: reset, asynchronous assert, active-low.
- `HOST_DATA` in 8: payload byte.
- `HOST_EOF` in 1: marks `HOST_DATA` as the last byte of its frame.
- `HOST_WR` in 1: single-cycle write strobe, synchronous to `BIT_CLK`.
- `FIFO_FULL` out 1: FIFO holds `FIFO_DEPTH` entries.
- `FIFO_LEVEL` out $clog2(FIFO_DEPTH)+1: current entry count.
- `TX_DATA` out 9: word to the transmitter. Bit 8 = raw (no zero insertion).
- `TX_WR` out 1: write strobe to the transmitter. The transmitter latches on the rising edge.
- `TX_THRE` in 1: transmitter holding-register-empty flag. Not assumed synchronous.
- `FRAME_DONE` out 1: one-cycle pulse when the closing flag is written.
- `ABORT` out 1: one-cycle pulse when an abort word is written.

## Operation
- Reset values: `TX_DATA`=0x17E, `TX_WR`=0, `FIFO_FULL`=0, `FIFO_LEVEL`=0, `FRAME_DONE`=0, `ABORT`=0. Reset also empties the FIFO, sets the state to IDLE, clears the flag count, and sets CRC=0xFFFF.
- FIFO entries are 9 bits: `{eof, byte}`.
  - A write when full is discarded, even if a pop happens in the same cycle.
  - A write and a pop in the same cycle on a non-full FIFO leaves the level unchanged.
- `TX_THRE` passes through a 2-flop synchronizer to give `thre_s`. All handshake decisions use `thre_s`.
- Word slot: when `thre_s`=1 and no write is outstanding, the FSM selects the next word.
  - The selected word is registered onto `TX_DATA` on the next edge.
  - `TX_WR` is high for exactly one cycle, on the edge after that.
  - The write is outstanding until `thre_s`=0 is seen. No new slot opens before then.
- States:
  - IDLE: each slot sends a flag, 0x17E, and increments the saturating flag count. When the count is at least `MIN_FLAGS` and the FIFO is non-empty, go to DATA. The last flag sent in IDLE is the opening flag.
  - DATA: pop an entry and send `{0, byte}`; CRC absorbs the byte.
    - If the entry has `eof`=1, go to FCS_HI.
    - If the FIFO is empty at a DATA slot, send abort 0x1FF, pulse `ABORT`, clear the flag count and CRC, and go to IDLE.
  - FCS_HI: send `{0, ~crc[15:8]}`, then go to FCS_LO.
  - FCS_LO: send `{0, ~crc[7:0]}`, then go to CLOSE.
  - CLOSE: send 0x17E, pulse `FRAME_DONE`, set the flag count to 1, set CRC=0xFFFF, and go to IDLE.
- CRC: CRC-16, polynomial 0x1021, MSB-first, non-reflected, init 0xFFFF. The FCS is the complement of the CRC, sent high byte first. This matches the transmitter's MSB-first shift.
- A one-byte frame is legal. A frame with zero bytes cannot be expressed.
- `FRAME_DONE` and `ABORT` pulse in the same cycle as the corresponding `TX_WR`.

## Timing
- Slot decision to `TX_WR` high: 2 cycles. `TX_DATA` is stable at least 1 cycle before the rising edge of `TX_WR` and holds until the next slot's register update.
- Latency from `TX_WR` to the next slot: at least 2 cycles of sync delay on the falling `thre_s`, plus the transmitter's drain time (about 8 or more bit clocks).
- Latency from `HOST_WR` to `FIFO_LEVEL` update: 1 cycle.
- When the FIFO is non-empty, the first payload byte goes out in the first slot after the `MIN_FLAGS` condition holds.
- A reset mid-frame truncates the frame without sending an abort. The downstream transmitter resynchronises on the following flags.

## Structure
- Package `hdlc_pkg` holds:
  - constants `FLAG_WORD`=9'h17E, `ABORT_WORD`=9'h1FF, `CRC_POLY`=16'h1021, `CRC_INIT`=16'hFFFF;
  - the state enum {IDLE, DATA, FCS_HI, FCS_LO, CLOSE}.
- Sub-module `crc16_ccitt`: registered byte-wide update with `init`, `en` and `data[7:0]` inputs and a `crc[15:0]` output.
- The FIFO, synchronizer and FSM stay inline in `hdlc_framer`.

## Test plan
- Reset, then `TX_THRE` held at 1 with `TX_WR` causing a 1-cycle low ack: only 0x17E words are written, `TX_WR` pulses are single-cycle, and `FIFO_LEVEL`=0.
- Payload "123456789" written with eof on '9', `MIN_FLAGS`=1: after the flags, words are 0x031..0x039, then 0x0D6, 0x04E, 0x17E. `FRAME_DONE` pulses once, then flags resume.
- 3-byte frame with eof missing, FIFO drained: 3 data words, then 0x1FF with `ABORT` pulse, then at least 1 flag before the next frame's data.
- Write 17 bytes to a 16-entry FIFO with `TX_THRE` held at 0: `FIFO_FULL`=1 and `FIFO_LEVEL`=16; the 17th byte is discarded, and the transmitted payload is bytes 1..16 only.
- `MIN_FLAGS`=3 with two back-to-back frames queued: exactly 3 flags (the closing flag plus 2) separate the frames.
- `nRESET` asserted during FCS_HI: outputs return to reset values immediately; after release, the first word is 0x17E and the old FIFO contents are not sent.

Source files
------------

// File: rtl/hdlc_pkg.sv
// Shared constants, FSM state type and CRC helper for the HDLC framer.
package hdlc_pkg;

  localparam logic [8:0]  FLAG_WORD  = 9'h17E;
  localparam logic [8:0]  ABORT_WORD = 9'h1FF;
  localparam logic [15:0] CRC_POLY   = 16'h1021;
  localparam logic [15:0] CRC_INIT   = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    FCS_HI,
    FCS_LO,
    CLOSE
  } state_t;

  // One byte of CRC-16 (0x1021), MSB-first, non-reflected, unrolled bit by bit.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[15] ^ data[3'(7 - i)];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/hdlc_framer_crc16_ccitt.sv
// Registered byte-wide CRC-16/CCITT accumulator; init has priority over en.
module crc16_ccitt
  import hdlc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // Next CRC value: reload, absorb a byte, or hold.
  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc16_byte(crc_q, data);
    end
  end

  // CRC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/hdlc_framer.sv
// HDLC framer: payload FIFO, THRE synchronizer and framing FSM feeding the
// SDLC transmitter holding register with {raw, byte} words.
module hdlc_framer
  import hdlc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MIN_FLAGS  = 1
) (
  input  logic                          BIT_CLK,
  input  logic                          nRESET,
  input  logic [7:0]                    HOST_DATA,
  input  logic                          HOST_EOF,
  input  logic                          HOST_WR,
  output logic                          FIFO_FULL,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic [8:0]                    TX_DATA,
  output logic                          TX_WR,
  input  logic                          TX_THRE,
  output logic                          FRAME_DONE,
  output logic                          ABORT
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_LVL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [3:0]  MIN_CNT   = 4'(MIN_FLAGS);

  // ---------------------------------------------------------------- FIFO
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          full, empty, push, pop;
  logic [8:0]    rd_word;

  assign full    = (level_q == DEPTH_LVL);
  assign empty   = (level_q == '0);
  assign push    = HOST_WR && !full;
  assign rd_word = mem_q[rd_ptr_q];

  // FIFO storage; entries are {eof, byte}.
  always_ff @(posedge BIT_CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {HOST_EOF, HOST_DATA};
    end
  end

  // Level follows push/pop; simultaneous push and pop cancel.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO pointers and level.
  always_ff @(posedge BIT_CLK or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // ---------------------------------------------------------- synchronizer
  logic thre_meta_q, thre_s_q;

  // Two-flop synchronizer on the transmitter's holding-register-empty flag.
  always_ff @(posedge BIT_CLK or negedge nRESET) begin
    if (!nRESET) begin
      thre_meta_q <= 1'b0;
      thre_s_q    <= 1'b0;
    end else begin
      thre_meta_q <= TX_THRE;
      thre_s_q    <= thre_meta_q;
    end
  end

  // ------------------------------------------------------------------ FSM
  state_t      state_q;
  logic [3:0]  flag_cnt_q, cnt_inc;
  logic [8:0]  tx_data_q;
  logic        pend_q;
  logic        stage_wr_q, stage_done_q, stage_abort_q;
  logic        tx_wr_q, frame_done_q, abort_q;
  logic        slot;
  logic        crc_init, crc_en;
  logic [15:0] crc;

  // A slot opens only once the previous write has been acknowledged by
  // thre_s dropping, so the same THRE high phase is never used twice.
  assign slot     = thre_s_q && !pend_q;
  assign pop      = slot && (state_q == DATA) && !empty;
  assign crc_en   = pop;
  assign crc_init = slot && (((state_q == DATA) && empty) || (state_q == CLOSE));
  assign cnt_inc  = (flag_cnt_q == 4'hF) ? 4'hF : flag_cnt_q + 4'd1;

  crc16_ccitt u_crc (
    .clk   (BIT_CLK),
    .rst_n (nRESET),
    .init  (crc_init),
    .en    (crc_en),
    .data  (rd_word[7:0]),
    .crc   (crc)
  );

  // Framing FSM: selects a word per slot, then delays the strobe and the
  // frame/abort pulses one extra cycle so TX_DATA settles before TX_WR.
  always_ff @(posedge BIT_CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q       <= IDLE;
      flag_cnt_q    <= '0;
      tx_data_q     <= FLAG_WORD;
      pend_q        <= 1'b0;
      stage_wr_q    <= 1'b0;
      stage_done_q  <= 1'b0;
      stage_abort_q <= 1'b0;
      tx_wr_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      tx_wr_q       <= stage_wr_q;
      frame_done_q  <= stage_done_q;
      abort_q       <= stage_abort_q;
      stage_wr_q    <= slot;
      stage_done_q  <= 1'b0;
      stage_abort_q <= 1'b0;

      if (slot) begin
        pend_q <= 1'b1;
      end else if (!thre_s_q) begin
        pend_q <= 1'b0;
      end

      if (slot) begin
        case (state_q)
          IDLE: begin
            tx_data_q  <= FLAG_WORD;
            flag_cnt_q <= cnt_inc;
            if ((cnt_inc >= MIN_CNT) && !empty) state_q <= DATA;
          end
          DATA: begin
            if (empty) begin
              tx_data_q     <= ABORT_WORD;
              stage_abort_q <= 1'b1;
              flag_cnt_q    <= '0;
              state_q       <= IDLE;
            end else begin
              tx_data_q <= {1'b0, rd_word[7:0]};
              if (rd_word[8]) state_q <= FCS_HI;
            end
          end
          FCS_HI: begin
            tx_data_q <= {1'b0, ~crc[15:8]};
            state_q   <= FCS_LO;
          end
          FCS_LO: begin
            tx_data_q <= {1'b0, ~crc[7:0]};
            state_q   <= CLOSE;
          end
          CLOSE: begin
            tx_data_q    <= FLAG_WORD;
            stage_done_q <= 1'b1;
            flag_cnt_q   <= 4'd1;
            state_q      <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end else if ((state_q == IDLE) && (flag_cnt_q >= MIN_CNT) && !empty) begin
        // Enough flags already sent: arm DATA so the next slot carries payload.
        state_q <= DATA;
      end
    end
  end

  assign FIFO_FULL  = full;
  assign FIFO_LEVEL = level_q;
  assign TX_DATA    = tx_data_q;
  assign TX_WR      = tx_wr_q;
  assign FRAME_DONE = frame_done_q;
  assign ABORT      = abort_q;

endmodule

// File: tb/tb_hdlc_framer.sv
// Directed bench for hdlc_framer: two instances (MIN_FLAGS 1 and 3), each
// driven by a small transmitter model that logs every written word.
module tb_hdlc_framer;

  localparam int DRAIN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A (MIN_FLAGS=1)
  logic       rst_a = 1'b0, wr_a = 1'b0, eof_a = 1'b0, hold_a = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic       full_a, tx_wr_a, done_a, abort_a;
  logic [4:0] lvl_a;
  logic [8:0] txd_a;
  logic       thre_a = 1'b1;
  int         cnt_a = 0, multi_a = 0, stray_a = 0;
  logic       wr_prev_a = 1'b0;

  // DUT B (MIN_FLAGS=3)
  logic       rst_b = 1'b0, wr_b = 1'b0, eof_b = 1'b0;
  logic [7:0] data_b = 8'h00;
  logic       full_b, tx_wr_b, done_b, abort_b;
  logic [4:0] lvl_b;
  logic [8:0] txd_b;
  logic       thre_b = 1'b1;
  int         cnt_b = 0, multi_b = 0, stray_b = 0;
  logic       wr_prev_b = 1'b0;

  // Logged entries are {abort, frame_done, word}.
  logic [10:0] qa[$];
  logic [10:0] qb[$];
  logic [10:0] cap[$];
  logic [7:0]  exp_pl [0:31];

  int errors = 0;
  int checks = 0;

  hdlc_framer #(.FIFO_DEPTH(16), .MIN_FLAGS(1)) u_dut_a (
    .BIT_CLK(clk), .nRESET(rst_a), .HOST_DATA(data_a), .HOST_EOF(eof_a),
    .HOST_WR(wr_a), .FIFO_FULL(full_a), .FIFO_LEVEL(lvl_a), .TX_DATA(txd_a),
    .TX_WR(tx_wr_a), .TX_THRE(thre_a), .FRAME_DONE(done_a), .ABORT(abort_a)
  );

  hdlc_framer #(.FIFO_DEPTH(16), .MIN_FLAGS(3)) u_dut_b (
    .BIT_CLK(clk), .nRESET(rst_b), .HOST_DATA(data_b), .HOST_EOF(eof_b),
    .HOST_WR(wr_b), .FIFO_FULL(full_b), .FIFO_LEVEL(lvl_b), .TX_DATA(txd_b),
    .TX_WR(tx_wr_b), .TX_THRE(thre_b), .FRAME_DONE(done_b), .ABORT(abort_b)
  );

  // Transmitter model A: latch on TX_WR, drop THRE for a drain period.
  always @(negedge clk) begin
    if (tx_wr_a) begin
      qa.push_back({abort_a, done_a, txd_a});
      cnt_a  <= DRAIN;
      thre_a <= 1'b0;
    end else if (cnt_a > 1) begin
      cnt_a  <= cnt_a - 1;
      thre_a <= 1'b0;
    end else begin
      cnt_a  <= 0;
      thre_a <= !hold_a;
    end
    if (tx_wr_a && wr_prev_a) multi_a <= multi_a + 1;
    if ((done_a || abort_a) && !tx_wr_a) stray_a <= stray_a + 1;
    wr_prev_a <= tx_wr_a;
  end

  // Transmitter model B.
  always @(negedge clk) begin
    if (tx_wr_b) begin
      qb.push_back({abort_b, done_b, txd_b});
      cnt_b  <= DRAIN;
      thre_b <= 1'b0;
    end else if (cnt_b > 1) begin
      cnt_b  <= cnt_b - 1;
      thre_b <= 1'b0;
    end else begin
      cnt_b  <= 0;
      thre_b <= 1'b1;
    end
    if (tx_wr_b && wr_prev_b) multi_b <= multi_b + 1;
    if ((done_b || abort_b) && !tx_wr_b) stray_b <= stray_b + 1;
    wr_prev_b <= tx_wr_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC: whole byte XORed into the top, then eight shifts.
  function automatic logic [15:0] crc_ref(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  function automatic logic [10:0] get(input int idx);
    if (idx >= 0 && idx < cap.size()) return cap[idx];
    return 11'h7FF;
  endfunction

  function automatic int find_ne_flag(input int from);
    for (int i = from; i < cap.size(); i++) if (cap[i] != 11'h17E) return i;
    return -1;
  endfunction

  function automatic int find_eq(input int from, input logic [10:0] v);
    for (int i = from; i < cap.size(); i++) if (cap[i] == v) return i;
    return -1;
  endfunction

  function automatic int cap_count(input logic [10:0] mask, input logic [10:0] v);
    int n = 0;
    for (int i = 0; i < cap.size(); i++) if ((cap[i] & mask) == v) n++;
    return n;
  endfunction

  function automatic int q_count(input bit b, input logic [10:0] mask, input logic [10:0] v);
    int n = 0;
    if (!b) begin
      for (int i = 0; i < qa.size(); i++) if ((qa[i] & mask) == v) n++;
    end else begin
      for (int i = 0; i < qb.size(); i++) if ((qb[i] & mask) == v) n++;
    end
    return n;
  endfunction

  task automatic wait_for(input string tag, input bit b, input logic [10:0] mask,
                          input logic [10:0] v, input int need);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (q_count(b, mask, v) >= need) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1);
  endtask

  task automatic host_wr(input bit b, input logic [7:0] d, input logic e);
    @(negedge clk);
    if (!b) begin data_a = d; eof_a = e; wr_a = 1'b1; end
    else    begin data_b = d; eof_b = e; wr_b = 1'b1; end
    @(negedge clk);
    wr_a = 1'b0;
    wr_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Checks opening..closing of a frame whose payload is exp_pl[0..nb-1].
  task automatic check_frame(input string tag, input int from, input int nb, output int close_idx);
    int k;
    logic [15:0] c;
    k = find_ne_flag(from);
    chk({tag, "_found"}, (k >= 0), 1);
    c = 16'hFFFF;
    for (int j = 0; j < nb; j++) begin
      chk({tag, "_data"}, get(k + j), {3'b000, exp_pl[j]});
      c = crc_ref(c, exp_pl[j]);
    end
    c = ~c;
    chk({tag, "_fcs_hi"}, get(k + nb), {3'b000, c[15:8]});
    chk({tag, "_fcs_lo"}, get(k + nb + 1), {3'b000, c[7:0]});
    chk({tag, "_close"}, get(k + nb + 2), 11'h37E);
    close_idx = k + nb + 2;
  endtask

  initial begin
    int ci, ci2, a, d;

    // ---------------- reset values
    idle(3);
    chk("rst_txdata", txd_a, 9'h17E);
    chk("rst_txwr",   tx_wr_a, 0);
    chk("rst_full",   full_a, 0);
    chk("rst_level",  lvl_a, 0);
    chk("rst_done",   done_a, 0);
    chk("rst_abort",  abort_a, 0);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // ---------------- idle flags only
    idle(60);
    cap = qa;
    chk("idle_some_words", (cap.size() > 2), 1);
    for (int i = 0; i < cap.size(); i++) chk("idle_flag", cap[i], 11'h17E);
    chk("idle_level", lvl_a, 0);

    // ---------------- "123456789"
    qa.delete();
    for (int i = 0; i < 9; i++) begin
      exp_pl[i] = 8'h31 + 8'(i);
      host_wr(0, exp_pl[i], i == 8);
    end
    wait_for("tmo_frame9", 0, 11'h200, 11'h200, 1);
    idle(30);
    cap = qa;
    check_frame("frame9", 0, 9, ci);
    chk("frame9_fcs_hi_const", get(ci - 2), 11'h0D6);
    chk("frame9_fcs_lo_const", get(ci - 1), 11'h04E);
    chk("frame9_flag_after", get(ci + 1), 11'h17E);
    chk("frame9_done_once", cap_count(11'h200, 11'h200), 1);
    chk("frame9_no_abort", cap_count(11'h400, 11'h400), 0);

    // ---------------- underrun -> abort, then a one-byte frame
    qa.delete();
    host_wr(0, 8'hA1, 0);
    host_wr(0, 8'hA2, 0);
    host_wr(0, 8'hA3, 0);
    wait_for("tmo_abort", 0, 11'h400, 11'h400, 1);
    host_wr(0, 8'h55, 1);
    wait_for("tmo_post_abort", 0, 11'h200, 11'h200, 1);
    idle(20);
    cap = qa;
    a = find_eq(0, 11'h5FF);
    chk("abort_found", (a >= 3), 1);
    chk("abort_d0", get(a - 3), 11'h0A1);
    chk("abort_d1", get(a - 2), 11'h0A2);
    chk("abort_d2", get(a - 1), 11'h0A3);
    chk("abort_flag_after", get(a + 1), 11'h17E);
    d = find_eq(a + 1, 11'h055);
    chk("abort_gap_flags", (d - a - 1 >= 1), 1);
    exp_pl[0] = 8'h55;
    check_frame("one_byte", a + 1, 1, ci);

    // ---------------- FIFO full with THRE held low
    hold_a = 1'b1;
    idle(12);
    qa.delete();
    for (int i = 1; i <= 17; i++) begin
      host_wr(0, 8'(i), i >= 16);
      if (i == 1)  chk("lvl_after_1", lvl_a, 1);
      if (i == 15) chk("not_full_15", full_a, 0);
      if (i == 16) begin
        chk("lvl_after_16", lvl_a, 16);
        chk("full_after_16", full_a, 1);
      end
      if (i == 17) begin
        chk("lvl_after_17", lvl_a, 16);
        chk("full_after_17", full_a, 1);
      end
    end
    for (int i = 0; i < 16; i++) exp_pl[i] = 8'(i + 1);
    hold_a = 1'b0;
    wait_for("tmo_full_frame", 0, 11'h200, 11'h200, 1);
    idle(20);
    cap = qa;
    check_frame("full16", 0, 16, ci);
    chk("full_no_byte17", cap_count(11'h7FF, 11'h011), 0);
    chk("full_level_empty", lvl_a, 0);

    // ---------------- MIN_FLAGS=3, back-to-back frames
    qb.delete();
    host_wr(1, 8'h10, 0);
    host_wr(1, 8'h20, 1);
    host_wr(1, 8'h30, 0);
    host_wr(1, 8'h40, 1);
    wait_for("tmo_b2b", 1, 11'h200, 11'h200, 2);
    idle(20);
    cap = qb;
    exp_pl[0] = 8'h10;
    exp_pl[1] = 8'h20;
    check_frame("b2b_f1", 0, 2, ci);
    chk("b2b_gap_flag1", get(ci + 1), 11'h17E);
    chk("b2b_gap_flag2", get(ci + 2), 11'h17E);
    chk("b2b_f2_start", get(ci + 3), 11'h030);
    exp_pl[0] = 8'h30;
    exp_pl[1] = 8'h40;
    check_frame("b2b_f2", ci + 1, 2, ci2);

    // ---------------- reset during FCS_HI
    qa.delete();
    host_wr(0, 8'h61, 0);
    host_wr(0, 8'h62, 1);
    host_wr(0, 8'h63, 0);
    host_wr(0, 8'h64, 1);
    wait_for("tmo_last_byte", 0, 11'h7FF, 11'h062, 1);
    #1 rst_a = 1'b0;
    #1;
    chk("mid_rst_txdata", txd_a, 9'h17E);
    chk("mid_rst_txwr",   tx_wr_a, 0);
    chk("mid_rst_level",  lvl_a, 0);
    chk("mid_rst_full",   full_a, 0);
    chk("mid_rst_done",   done_a, 0);
    chk("mid_rst_abort",  abort_a, 0);
    idle(3);
    qa.delete();
    rst_a = 1'b1;
    idle(60);
    cap = qa;
    chk("post_rst_words", (cap.size() > 2), 1);
    chk("post_rst_first", get(0), 11'h17E);
    for (int i = 0; i < cap.size(); i++) chk("post_rst_flag", cap[i], 11'h17E);

    // ---------------- strobe shape
    chk("a_wr_single_cycle", multi_a, 0);
    chk("b_wr_single_cycle", multi_b, 0);
    chk("a_pulse_with_wr", stray_a, 0);
    chk("b_pulse_with_wr", stray_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
